// File: rtl/i_cache_stream_prefetch_control_if.sv
// Fetch, datapath and memory-side signals of the I-cache stream prefetch controller.
// master: the surrounding fetch stage / datapath / memory arbiter.
// slave: the controller.
interface i_cache_stream_prefetch_control_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_read;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_resp;
   logic                  demand_hit;
   logic                  hit_prefetched;
   logic                  load_lru;
   logic [ADDR_WIDTH-1:0] probe_addr;
   logic                  probe_hit;
   logic [ADDR_WIDTH-1:0] fill_addr;
   logic                  read_from_mem;
   logic                  resp_from_mem;
   logic                  load_cache;
   logic                  fill_is_prefetch;

   modport master (
      output mem_read, mem_address, demand_hit, hit_prefetched, probe_hit, resp_from_mem,
      input  mem_resp, load_lru, probe_addr, fill_addr, read_from_mem, load_cache, fill_is_prefetch
   );

   modport slave (
      input  mem_read, mem_address, demand_hit, hit_prefetched, probe_hit, resp_from_mem,
      output mem_resp, load_lru, probe_addr, fill_addr, read_from_mem, load_cache, fill_is_prefetch
   );
endinterface

// File: rtl/i_cache_stream_prefetch_control.sv
// I-cache controller with a depth-PF_DEPTH next-line stream prefetcher.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no memory traffic; serves hits, starts demand fills/streams
// DEMAND_FILL | demand miss line being read from memory
// PF_PROBE    | probing the next candidate line of the stream in the tags
// PF_FILL     | prefetch line being read from memory (never aborted)
module i_cache_stream_prefetch_control #(
   parameter int ADDR_WIDTH       = 32,
   parameter int LINE_OFFSET_BITS = 5,
   parameter int PF_DEPTH         = 2,
   parameter int CNT_WIDTH        = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pf_enable,
   i_cache_stream_prefetch_control_if.slave bus,
   output logic [CNT_WIDTH-1:0] hit_cnt,
   output logic [CNT_WIDTH-1:0] miss_cnt,
   output logic [CNT_WIDTH-1:0] pf_issue_cnt,
   output logic [CNT_WIDTH-1:0] pf_useful_cnt,
   output logic [CNT_WIDTH-1:0] miss_wait_cnt
);

   localparam int LINE_W = ADDR_WIDTH - LINE_OFFSET_BITS;
   localparam int REM_W  = 4;
   localparam int OFF_W  = 5;

   localparam logic [REM_W-1:0] PF_DEPTH_C = REM_W'(PF_DEPTH);
   localparam logic             PF_BUILT  = (PF_DEPTH > 0);

   typedef enum logic [1:0] {
      IDLE,
      DEMAND_FILL,
      PF_PROBE,
      PF_FILL
   } state_t;

   state_t              state;
   logic [LINE_W-1:0]   pf_base;
   logic [REM_W-1:0]    pf_remaining;
   logic [LINE_W-1:0]   fill_line;
   logic                rebase_pending;
   logic [LINE_W-1:0]   rebase_base;
   logic                rd_q;
   logic                pf_fill_q;

   logic [LINE_W-1:0]   demand_line;
   logic                fill_resp;
   logic                hit_req;
   logic                miss_req;
   logic                serve;
   logic                other_line;
   logic [OFF_W-1:0]    cand_offset;
   logic [LINE_W:0]     cand_sum;
   logic                cand_carry;
   logic [LINE_W-1:0]   cand_line;
   logic                start_demand;
   logic                start_pf;
   logic                probe_act;

   assign demand_line = bus.mem_address[ADDR_WIDTH-1:LINE_OFFSET_BITS];
   assign fill_resp   = rd_q & bus.resp_from_mem;
   assign hit_req     = bus.mem_read & bus.demand_hit;
   assign miss_req    = bus.mem_read & ~bus.demand_hit;
   assign other_line  = (demand_line != pf_base);

   // Hits are answered combinationally, except while a returning line is being written.
   assign serve       = rst & hit_req & ~fill_resp;

   // Candidate line = pf_base + (PF_DEPTH - pf_remaining + 1); the extra MSB flags wrap-around.
   always_comb begin
      cand_offset = OFF_W'(PF_DEPTH_C) - OFF_W'(pf_remaining) + OFF_W'(1);
      cand_sum    = {1'b0, pf_base} + (LINE_W+1)'(cand_offset);
      cand_carry  = cand_sum[LINE_W];
      cand_line   = cand_sum[LINE_W-1:0];
   end

   // Decisions shared between the state machine and the performance counters.
   always_comb begin
      start_demand = 1'b0;
      start_pf     = 1'b0;
      probe_act    = 1'b0;
      if (state == IDLE) begin
         start_demand = miss_req;
      end else if (state == PF_PROBE && pf_enable) begin
         start_demand = miss_req;
         probe_act    = ~miss_req & ~(serve & other_line) &
                        (pf_remaining != '0) & ~cand_carry;
         start_pf     = probe_act & ~bus.probe_hit;
      end
   end

   assign bus.mem_resp         = serve;
   assign bus.load_lru         = serve;
   assign bus.load_cache       = fill_resp;
   assign bus.read_from_mem    = rd_q;
   assign bus.fill_is_prefetch = pf_fill_q;
   assign bus.fill_addr        = {fill_line, {LINE_OFFSET_BITS{1'b0}}};
   assign bus.probe_addr       = (state == PF_PROBE) ? {cand_line, {LINE_OFFSET_BITS{1'b0}}}
                                                     : '0;

   // Controller state machine with registered memory-request outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         pf_base        <= '0;
         pf_remaining   <= '0;
         fill_line      <= '0;
         rebase_pending <= 1'b0;
         rebase_base    <= '0;
         rd_q           <= 1'b0;
         pf_fill_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_demand) begin
                  fill_line <= demand_line;
                  rd_q      <= 1'b1;
                  pf_fill_q <= 1'b0;
                  state     <= DEMAND_FILL;
               end else if (serve && pf_enable && PF_BUILT) begin
                  pf_base      <= demand_line;
                  pf_remaining <= PF_DEPTH_C;
                  state        <= PF_PROBE;
               end
            end

            DEMAND_FILL: begin
               if (bus.resp_from_mem) begin
                  rd_q  <= 1'b0;
                  state <= IDLE;
               end
            end

            PF_PROBE: begin
               if (!pf_enable) begin
                  pf_remaining <= '0;
                  state        <= IDLE;
               end else if (start_demand) begin
                  pf_remaining <= '0;
                  fill_line    <= demand_line;
                  rd_q         <= 1'b1;
                  pf_fill_q    <= 1'b0;
                  state        <= DEMAND_FILL;
               end else if (serve && other_line) begin
                  pf_base      <= demand_line;
                  pf_remaining <= PF_DEPTH_C;
               end else if (!probe_act) begin
                  // Stream exhausted or the next line would wrap past the top of memory.
                  pf_remaining <= '0;
                  state        <= IDLE;
               end else if (bus.probe_hit) begin
                  pf_remaining <= pf_remaining - REM_W'(1);
                  if (pf_remaining == REM_W'(1)) begin
                     state <= IDLE;
                  end
               end else begin
                  fill_line <= cand_line;
                  rd_q      <= 1'b1;
                  pf_fill_q <= 1'b1;
                  state     <= PF_FILL;
               end
            end

            PF_FILL: begin
               if (serve && other_line) begin
                  rebase_pending <= 1'b1;
                  rebase_base    <= demand_line;
               end
               if (bus.resp_from_mem) begin
                  rd_q      <= 1'b0;
                  pf_fill_q <= 1'b0;
                  if (miss_req) begin
                     // Back to IDLE so the miss is re-evaluated against the line just written.
                     pf_remaining   <= '0;
                     rebase_pending <= 1'b0;
                     state          <= IDLE;
                  end else if (rebase_pending) begin
                     pf_base        <= rebase_base;
                     pf_remaining   <= PF_DEPTH_C;
                     rebase_pending <= 1'b0;
                     state          <= PF_PROBE;
                  end else if (pf_remaining > REM_W'(1)) begin
                     pf_remaining <= pf_remaining - REM_W'(1);
                     state        <= PF_PROBE;
                  end else begin
                     pf_remaining <= '0;
                     state        <= IDLE;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic                 en);
      return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
   endfunction

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt       <= '0;
         miss_cnt      <= '0;
         pf_issue_cnt  <= '0;
         pf_useful_cnt <= '0;
         miss_wait_cnt <= '0;
      end else begin
         hit_cnt       <= sat_inc(hit_cnt, serve);
         miss_cnt      <= sat_inc(miss_cnt, start_demand);
         pf_issue_cnt  <= sat_inc(pf_issue_cnt, start_pf);
         pf_useful_cnt <= sat_inc(pf_useful_cnt, serve & bus.hit_prefetched);
         miss_wait_cnt <= sat_inc(miss_wait_cnt, (state == PF_FILL) & miss_req);
      end
   end

endmodule

// File: tb/tb_i_cache_stream_prefetch_control.sv
module tb_i_cache_stream_prefetch_control;

   logic clk;
   logic rst;
   logic pf_enable;

   logic [31:0] hit_cnt, miss_cnt, pf_issue_cnt, pf_useful_cnt, miss_wait_cnt;
   logic [3:0]  hit_cnt1, miss_cnt1, pf_issue_cnt1, pf_useful_cnt1, miss_wait_cnt1;

   int n_checks;
   int n_fail;

   i_cache_stream_prefetch_control_if #(.ADDR_WIDTH(32)) bi0 ();
   i_cache_stream_prefetch_control_if #(.ADDR_WIDTH(32)) bi1 ();

   i_cache_stream_prefetch_control #(
      .ADDR_WIDTH(32), .LINE_OFFSET_BITS(5), .PF_DEPTH(2), .CNT_WIDTH(32)
   ) u_dut (
      .clk(clk), .rst(rst), .pf_enable(pf_enable), .bus(bi0),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .pf_issue_cnt(pf_issue_cnt),
      .pf_useful_cnt(pf_useful_cnt), .miss_wait_cnt(miss_wait_cnt)
   );

   // Prefetch structurally removed and 4-bit counters, for saturation checks.
   i_cache_stream_prefetch_control #(
      .ADDR_WIDTH(32), .LINE_OFFSET_BITS(5), .PF_DEPTH(0), .CNT_WIDTH(4)
   ) u_dut_small (
      .clk(clk), .rst(rst), .pf_enable(pf_enable), .bus(bi1),
      .hit_cnt(hit_cnt1), .miss_cnt(miss_cnt1), .pf_issue_cnt(pf_issue_cnt1),
      .pf_useful_cnt(pf_useful_cnt1), .miss_wait_cnt(miss_wait_cnt1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bi0.mem_read = 1'b0; bi0.mem_address = '0; bi0.demand_hit = 1'b0;
      bi0.hit_prefetched = 1'b0; bi0.probe_hit = 1'b0; bi0.resp_from_mem = 1'b0;
      bi1.mem_read = 1'b0; bi1.mem_address = '0; bi1.demand_hit = 1'b0;
      bi1.hit_prefetched = 1'b0; bi1.probe_hit = 1'b0; bi1.resp_from_mem = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      pf_enable = 1'b1;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic fetch(input logic [31:0] addr, input logic hit);
      bi0.mem_read = 1'b1; bi0.mem_address = addr; bi0.demand_hit = hit;
   endtask

   task automatic drop_fetch();
      bi0.mem_read = 1'b0; bi0.demand_hit = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      pf_enable = 1'b1;
      fetch(32'h100, 1'b1);
      step();
      step();
      n_checks++;
      if ({bi0.mem_resp, bi0.load_lru, bi0.read_from_mem, bi0.load_cache, bi0.fill_is_prefetch} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_bits: got %b expected 00000", {bi0.mem_resp, bi0.load_lru,
                  bi0.read_from_mem, bi0.load_cache, bi0.fill_is_prefetch});
      end
      n_checks++;
      if (bi0.probe_addr !== 32'h0 || bi0.fill_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_addr: probe %h fill %h expected 0 0", bi0.probe_addr, bi0.fill_addr);
      end
      n_checks++;
      if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_cnt: hit %0d miss %0d expected 0 0", hit_cnt, miss_cnt);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (bi0.mem_resp !== 1'b1 || bi0.load_lru !== 1'b1) begin
         n_fail++;
         $display("FAIL first_hit_resp: mem_resp %b load_lru %b expected 1 1", bi0.mem_resp, bi0.load_lru);
      end
      step();
      drop_fetch();
      #1;
      n_checks++;
      if (bi0.probe_addr !== 32'h120) begin
         n_fail++;
         $display("FAIL first_probe_addr: got %h expected 00000120", bi0.probe_addr);
      end
      n_checks++;
      if (hit_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL first_hit_cnt: got %0d expected 1", hit_cnt);
      end
   endtask

   task automatic test_two_fills();
      do_reset();
      fetch(32'h100, 1'b1);
      step();
      drop_fetch();
      step();
      n_checks++;
      if (bi0.read_from_mem !== 1'b1 || bi0.fill_is_prefetch !== 1'b1 || bi0.fill_addr !== 32'h120) begin
         n_fail++;
         $display("FAIL pf_fill1: rd %b pf %b addr %h expected 1 1 00000120",
                  bi0.read_from_mem, bi0.fill_is_prefetch, bi0.fill_addr);
      end
      step();
      step();
      bi0.resp_from_mem = 1'b1;
      fetch(32'h100, 1'b1);
      #1;
      n_checks++;
      if (bi0.load_cache !== 1'b1 || bi0.mem_resp !== 1'b0 || bi0.load_lru !== 1'b0) begin
         n_fail++;
         $display("FAIL resp_cycle: load_cache %b mem_resp %b load_lru %b expected 1 0 0",
                  bi0.load_cache, bi0.mem_resp, bi0.load_lru);
      end
      step();
      bi0.resp_from_mem = 1'b0;
      #1;
      n_checks++;
      if (bi0.mem_resp !== 1'b1 || bi0.probe_addr !== 32'h140) begin
         n_fail++;
         $display("FAIL deferred_hit_probe2: mem_resp %b probe %h expected 1 00000140",
                  bi0.mem_resp, bi0.probe_addr);
      end
      step();
      drop_fetch();
      n_checks++;
      if (bi0.fill_addr !== 32'h140 || bi0.fill_is_prefetch !== 1'b1 || pf_issue_cnt !== 32'd2 || hit_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL pf_fill2: addr %h pf %b issue %0d hit %0d expected 00000140 1 2 2",
                  bi0.fill_addr, bi0.fill_is_prefetch, pf_issue_cnt, hit_cnt);
      end
      step();
      bi0.resp_from_mem = 1'b1;
      step();
      bi0.resp_from_mem = 1'b0;
      step();
      n_checks++;
      if (bi0.read_from_mem !== 1'b0 || bi0.probe_addr !== 32'h0 || pf_issue_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL stream_done: rd %b probe %h issue %0d expected 0 0 2",
                  bi0.read_from_mem, bi0.probe_addr, pf_issue_cnt);
      end
   endtask

   task automatic test_miss_during_prefetch();
      do_reset();
      fetch(32'h100, 1'b1);
      step();
      drop_fetch();
      step();
      fetch(32'h200, 1'b0);
      #1;
      n_checks++;
      if (bi0.mem_resp !== 1'b0) begin
         n_fail++;
         $display("FAIL miss_withheld: mem_resp %b expected 0", bi0.mem_resp);
      end
      repeat (5) step();
      bi0.resp_from_mem = 1'b1;
      step();
      bi0.resp_from_mem = 1'b0;
      n_checks++;
      if (miss_wait_cnt !== 32'd6 || miss_cnt !== 32'd0 || bi0.read_from_mem !== 1'b0) begin
         n_fail++;
         $display("FAIL miss_wait: wait %0d miss %0d rd %b expected 6 0 0",
                  miss_wait_cnt, miss_cnt, bi0.read_from_mem);
      end
      step();
      n_checks++;
      if (bi0.read_from_mem !== 1'b1 || bi0.fill_is_prefetch !== 1'b0 || bi0.fill_addr !== 32'h200 || miss_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL demand_fill: rd %b pf %b addr %h miss %0d expected 1 0 00000200 1",
                  bi0.read_from_mem, bi0.fill_is_prefetch, bi0.fill_addr, miss_cnt);
      end
      step();
      bi0.resp_from_mem = 1'b1;
      step();
      bi0.resp_from_mem = 1'b0;
      bi0.demand_hit = 1'b1;
      step();
      drop_fetch();
      n_checks++;
      if (bi0.probe_addr !== 32'h220 || pf_issue_cnt !== 32'd1 || miss_wait_cnt !== 32'd6) begin
         n_fail++;
         $display("FAIL restart_stream: probe %h issue %0d wait %0d expected 00000220 1 6",
                  bi0.probe_addr, pf_issue_cnt, miss_wait_cnt);
      end
   endtask

   task automatic test_rebase();
      do_reset();
      fetch(32'h100, 1'b1);
      bi0.hit_prefetched = 1'b0;
      step();
      drop_fetch();
      step();
      fetch(32'h300, 1'b1);
      bi0.hit_prefetched = 1'b1;
      #1;
      n_checks++;
      if (bi0.mem_resp !== 1'b1) begin
         n_fail++;
         $display("FAIL hit_during_fill: mem_resp %b expected 1", bi0.mem_resp);
      end
      step();
      drop_fetch();
      bi0.hit_prefetched = 1'b0;
      step();
      bi0.resp_from_mem = 1'b1;
      step();
      bi0.resp_from_mem = 1'b0;
      n_checks++;
      if (bi0.probe_addr !== 32'h320 || hit_cnt !== 32'd2 || pf_useful_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL rebase_probe: probe %h hit %0d useful %0d expected 00000320 2 1",
                  bi0.probe_addr, hit_cnt, pf_useful_cnt);
      end
      bi0.probe_hit = 1'b1;
      step();
      n_checks++;
      if (bi0.probe_addr !== 32'h340) begin
         n_fail++;
         $display("FAIL probe_hit_advance: got %h expected 00000340", bi0.probe_addr);
      end
      step();
      bi0.probe_hit = 1'b0;
      n_checks++;
      if (bi0.probe_addr !== 32'h0 || bi0.read_from_mem !== 1'b0 || pf_issue_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL probe_hits_done: probe %h rd %b issue %0d expected 0 0 1",
                  bi0.probe_addr, bi0.read_from_mem, pf_issue_cnt);
      end
   endtask

   task automatic test_top_and_disable();
      do_reset();
      fetch(32'hFFFF_FFE0, 1'b1);
      step();
      drop_fetch();
      step();
      step();
      n_checks++;
      if (bi0.read_from_mem !== 1'b0 || bi0.probe_addr !== 32'h0 || pf_issue_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL top_of_memory: rd %b probe %h issue %0d expected 0 0 0",
                  bi0.read_from_mem, bi0.probe_addr, pf_issue_cnt);
      end
      pf_enable = 1'b0;
      fetch(32'h100, 1'b1);
      step();
      drop_fetch();
      n_checks++;
      if (bi0.probe_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL disabled_no_probe: got %h expected 0", bi0.probe_addr);
      end
      repeat (3) step();
      n_checks++;
      if (bi0.read_from_mem !== 1'b0 || pf_issue_cnt !== 32'd0 || hit_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL disabled_no_fill: rd %b issue %0d hit %0d expected 0 0 2",
                  bi0.read_from_mem, pf_issue_cnt, hit_cnt);
      end
      pf_enable = 1'b1;
      fetch(32'h100, 1'b1);
      step();
      drop_fetch();
      pf_enable = 1'b0;
      step();
      n_checks++;
      if (bi0.probe_addr !== 32'h0 || bi0.read_from_mem !== 1'b0) begin
         n_fail++;
         $display("FAIL disable_mid_probe: probe %h rd %b expected 0 0", bi0.probe_addr, bi0.read_from_mem);
      end
      pf_enable = 1'b1;
   endtask

   task automatic test_reset_mid_fill();
      do_reset();
      fetch(32'h400, 1'b0);
      step();
      drop_fetch();
      n_checks++;
      if (bi0.read_from_mem !== 1'b1 || bi0.fill_addr !== 32'h400) begin
         n_fail++;
         $display("FAIL pre_reset_fill: rd %b addr %h expected 1 00000400", bi0.read_from_mem, bi0.fill_addr);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (bi0.read_from_mem !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_rd: got %b expected 0", bi0.read_from_mem);
      end
      #1;
      rst = 1'b1;
      bi0.resp_from_mem = 1'b1;
      #1;
      n_checks++;
      if (bi0.load_cache !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_resp: load_cache %b expected 0", bi0.load_cache);
      end
      step();
      bi0.resp_from_mem = 1'b0;
      n_checks++;
      if (bi0.read_from_mem !== 1'b0 || miss_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL after_stray: rd %b miss %0d expected 0 0", bi0.read_from_mem, miss_cnt);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      bi1.mem_read = 1'b1; bi1.mem_address = 32'h100;
      bi1.demand_hit = 1'b1; bi1.hit_prefetched = 1'b1;
      repeat (14) step();
      n_checks++;
      if (hit_cnt1 !== 4'd14) begin
         n_fail++;
         $display("FAIL sat_pre: hit_cnt %0d expected 14", hit_cnt1);
      end
      repeat (6) step();
      n_checks++;
      if (hit_cnt1 !== 4'hF || pf_useful_cnt1 !== 4'hF) begin
         n_fail++;
         $display("FAIL sat_hold: hit %h useful %h expected f f", hit_cnt1, pf_useful_cnt1);
      end
      n_checks++;
      if (bi1.probe_addr !== 32'h0 || bi1.read_from_mem !== 1'b0 || pf_issue_cnt1 !== 4'd0) begin
         n_fail++;
         $display("FAIL depth0_no_prefetch: probe %h rd %b issue %0d expected 0 0 0",
                  bi1.probe_addr, bi1.read_from_mem, pf_issue_cnt1);
      end
      n_checks++;
      if (hit_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL other_dut_quiet: hit_cnt %0d expected 0", hit_cnt);
      end
      bi1.mem_read = 1'b0; bi1.demand_hit = 1'b0; bi1.hit_prefetched = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_two_fills();
      test_miss_during_prefetch();
      test_rebase();
      test_top_and_disable();
      test_reset_mid_fill();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i_cache_stream_prefetch_control.md
Name: i_cache_stream_prefetch_control

Overview:
- Parametrised instruction-cache controller with a depth-N next-line stream prefetcher; generalises one-block-lookahead prefetch.
- Serves CPU fetch hits and demand misses, and probes and fills up to PF_DEPTH sequential lines ahead of the last demand line.
- Demand traffic always has priority over prefetch, and prefetch can be disabled at run time.
- Sits between the fetch stage, the I-cache datapath (tag/LRU arrays) and the memory arbiter; it exports saturating performance counters.

Parameters:
- ADDR_WIDTH, 32: byte address width.
- LINE_OFFSET_BITS, 5: log2 of line size in bytes (32-byte lines).
- PF_DEPTH, 2: lines prefetched ahead of the demand line, range 0..15. 0 disables prefetch structurally.
- CNT_WIDTH, 32: performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pf_enable  in  1  run-time prefetch enable.
- mem_read  in  1  CPU fetch request. The CPU holds it and mem_address stable until mem_resp.
- mem_address  in  ADDR_WIDTH  CPU fetch address.
- mem_resp  out  1  fetch complete this cycle.
- demand_hit  in  1  datapath tag hit for mem_address.
- hit_prefetched  in  1  the hit line was installed by a prefetch.
- load_lru  out  1  update LRU for the hitting way.
- probe_addr  out  ADDR_WIDTH  line-aligned candidate prefetch address for datapath tag probe.
- probe_hit  in  1  candidate line already present.
- fill_addr  out  ADDR_WIDTH  line-aligned address to memory.
- read_from_mem  out  1  memory read request, held until resp_from_mem.
- resp_from_mem  in  1  line returned this cycle.
- load_cache  out  1  write returned line into the LRU way.
- fill_is_prefetch  out  1  qualifies load_cache; sets the line's prefetched bit.
- hit_cnt, miss_cnt, pf_issue_cnt, pf_useful_cnt, miss_wait_cnt  out  CNT_WIDTH each  performance counters.

Behaviour:
- States: IDLE, DEMAND_FILL, PF_PROBE, PF_FILL.
- Registers: pf_base (line address), pf_remaining (0..PF_DEPTH), fill_addr register, rebase_pending with rebase_base.
- Reset (rst=0, asynchronous):
  - state=IDLE; all registers and counters = 0.
  - All 1-bit outputs 0; probe_addr and fill_addr 0.
- Candidate address: probe_addr = (pf_base + (PF_DEPTH - pf_remaining + 1)) << LINE_OFFSET_BITS.
  - If the increment carries past the top of the address space, the candidate is invalid: pf_remaining is cleared and prefetch stops.
- Demand hit, any state except the resp_from_mem cycle of a fill:
  - mem_read & demand_hit → mem_resp=1 and load_lru=1 combinationally; 0-cycle latency.
  - In the resp_from_mem cycle, mem_resp is suppressed (no same-cycle read/write of arrays); the hit is served next cycle.
- IDLE:
  - Demand hit → serve. If pf_enable and PF_DEPTH>0: pf_base = line(mem_address), pf_remaining = PF_DEPTH, next state PF_PROBE.
  - mem_read & ~demand_hit → latch fill_addr = line(mem_address) → DEMAND_FILL; miss_cnt++.
- DEMAND_FILL:
  - read_from_mem=1, fill_is_prefetch=0.
  - On resp_from_mem: load_cache=1 → IDLE. The re-presented fetch then hits one cycle later and starts the prefetch stream.
- PF_PROBE:
  - pf_enable=0 → pf_remaining cleared → IDLE.
  - mem_read & ~demand_hit → clear pf_remaining → DEMAND_FILL; miss_cnt++.
  - Demand hit to a line other than pf_base → serve, rebase (pf_base = new line, pf_remaining = PF_DEPTH); no probe acted on this cycle.
  - Otherwise, evaluate the probe (in parallel with a same-line hit if present):
    - probe_hit → pf_remaining--.
    - ~probe_hit → latch fill_addr = probe_addr → PF_FILL; pf_issue_cnt++.
  - pf_remaining reaching 0 → IDLE.
- PF_FILL:
  - read_from_mem=1, fill_is_prefetch=1. The transaction is never aborted.
  - Demand hit to a different line → serve, set rebase_pending and latch rebase_base.
  - Demand miss → mem_resp=0; miss_wait_cnt++ each cycle.
  - On resp_from_mem: load_cache=1, pf_remaining--, then the first matching rule applies:
    - mem_read & ~demand_hit → clear pf_remaining and rebase_pending → IDLE (re-evaluates; the fill may satisfy the miss).
    - rebase_pending → pf_base = rebase_base, pf_remaining = PF_DEPTH, clear flag → PF_PROBE.
    - pf_remaining>0 → PF_PROBE.
    - Otherwise → IDLE.
- Counters:
  - hit_cnt += mem_resp; pf_useful_cnt += mem_resp & hit_prefetched.
  - All counters saturate at all-ones; no wrap.
- Reset mid-fill:
  - Immediate return to IDLE with read_from_mem=0.
  - A stray resp_from_mem arriving in IDLE is ignored (no load_cache).

Test Plan:
1. Reset with mem_read=1 → all outputs 0 while rst=0. First clk after release with hit at 0x100: mem_resp=1, PF_PROBE; probe_addr=0x120.
2. PF_DEPTH=2, hit at 0x100, probe_hit=0 both → two PF_FILLs: fill_addr 0x120 then 0x140, fill_is_prefetch=1, pf_issue_cnt=2, then IDLE.
3. Miss at 0x200 during PF_FILL of 0x120, resp after 6 cycles → miss_wait_cnt=6, mem_resp withheld. Then IDLE → DEMAND_FILL at 0x200; miss_cnt=1; prefetch of 0x140 dropped.
4. Hit at 0x300 during PF_FILL of 0x120 → after resp, PF_PROBE with probe_addr=0x320.
5. Hit at 0xFFFFFFE0 with PF_DEPTH=2 → no probe issued (carry past top) → IDLE. pf_enable=0 → no probes ever.
6. Force hit_cnt to 0xFFFFFFFF, issue another hit → hit_cnt stays 0xFFFFFFFF.
